// File: rtl/sigma_pkg.sv
// -----------------------------------------------------------------------------
// sigma_pkg
// Shared types and helpers for the sigma accumulation lane.
//   sm_fixed_t    : 32-bit signed-magnitude fixed point (bit 31 sign,
//                   bits 30:0 magnitude, FRAC_BITS fractional bits)
//   sigma_state_e : accumulation controller states
//   sm_to_tc      : signed-magnitude -> 34-bit two's complement
//   tc_to_sm      : 34-bit two's complement -> signed-magnitude (zero is +0)
// -----------------------------------------------------------------------------
package sigma_pkg;

  typedef logic [31:0] sm_fixed_t;

  localparam int        FRAC_BITS   = 17;
  localparam sm_fixed_t SM_ZERO     = 32'h0000_0000;
  localparam sm_fixed_t SM_NEG_ZERO = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_GATHER = 2'd0,
    ST_ADD    = 2'd1,
    ST_DONE   = 2'd2
  } sigma_state_e;

  // 34 bits hold the sum of three 31-bit magnitudes plus a sign.
  function automatic logic signed [33:0] sm_to_tc(input sm_fixed_t v);
    logic signed [33:0] m;
    m = signed'({3'b000, v[30:0]});
    return v[31] ? -m : m;
  endfunction

  // A zero sum always comes back as +0; magnitudes beyond 31 bits wrap.
  function automatic sm_fixed_t tc_to_sm(input logic signed [33:0] t);
    logic [33:0] mag;
    mag = t[33] ? unsigned'(-t) : unsigned'(t);
    return {t[33], 31'(mag)};
  endfunction

endpackage

// File: rtl/sigma3.sv
// -----------------------------------------------------------------------------
// sigma3
// Combinational 3-input signed-magnitude adder.
//   a [0:2][1] : in  three sm_fixed_t operands (column 0 used)
//   c          : out signed-magnitude sum, unsaturated
// -----------------------------------------------------------------------------
module sigma3
  import sigma_pkg::*;
(
  input  sm_fixed_t a [0:2][1],
  output sm_fixed_t c
);

  logic signed [33:0] w_sum;

  always_comb begin
    w_sum = sm_to_tc(a[0][0]) + sm_to_tc(a[1][0]) + sm_to_tc(a[2][0]);
  end

  assign c = tc_to_sm(w_sum);

endmodule

// File: rtl/sigma_accum_ctrl.sv
// -----------------------------------------------------------------------------
// sigma_accum_ctrl
// Accumulates a stream of signed-magnitude terms into one frame sum by
// time-multiplexing a single sigma3 adder: each ADD pass folds the running
// accumulator with up to two buffered terms.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : term handshake; in_data term, in_last frame end
//   out_valid/out_ready : frame-sum handshake; out_data frame sum
//   busy                : frame in progress (terms accepted or output pending)
//   o_dbg_state         : current controller state (sigma_state_e encoding)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. ready never depends on valid; a holder of valid keeps its data stable
// until the transfer.
//
// Build option: define SIGMA_RELU_EN to force out_data to zero whenever the
// accumulator is negative (the accumulator itself is unchanged).
// -----------------------------------------------------------------------------
module sigma_accum_ctrl
  import sigma_pkg::*;
#(
  parameter int N_TERMS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy,
  output logic [1:0]  o_dbg_state
);

  localparam int            CW       = $clog2(N_TERMS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N_TERMS - 1);

  sigma_state_e  r_state;
  sigma_state_e  w_next_state;
  sm_fixed_t     r_acc;
  sm_fixed_t     r_s0;
  sm_fixed_t     r_s1;
  logic [1:0]    r_nslot;
  logic [CW-1:0] r_cnt;
  logic          r_fend;

  logic          w_accept;
  logic          w_frame_end;
  sm_fixed_t     w_a [0:2][1];
  sm_fixed_t     w_c;
  sm_fixed_t     w_out;

  assign in_ready    = (r_state == ST_GATHER);
  assign w_accept    = in_valid && in_ready;
  // The term that fills the last counter position closes the frame even
  // without in_last.
  assign w_frame_end = in_last || (r_cnt == LAST_CNT);

  // Third operand is zero when only one term was buffered before the pass.
  always_comb begin
    w_a[0][0] = r_acc;
    w_a[1][0] = r_s0;
    w_a[2][0] = (r_nslot == 2'd2) ? r_s1 : SM_ZERO;
  end

  sigma3 sigma3_0 (
    .a (w_a),
    .c (w_c)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_GATHER;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_GATHER: begin
        // r_nslot==1 means this accept fills the second slot.
        if (w_accept && ((r_nslot == 2'd1) || w_frame_end)) begin
          w_next_state = ST_ADD;
        end
      end
      ST_ADD: begin
        w_next_state = r_fend ? ST_DONE : ST_GATHER;
      end
      ST_DONE: begin
        if (out_ready) begin
          w_next_state = ST_GATHER;
        end
      end
      default: w_next_state = ST_GATHER;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= SM_ZERO;
      r_s0    <= SM_ZERO;
      r_s1    <= SM_ZERO;
      r_nslot <= 2'd0;
      r_cnt   <= '0;
      r_fend  <= 1'b0;
    end else begin
      case (r_state)
        ST_GATHER: begin
          if (w_accept) begin
            if (r_nslot == 2'd0) begin
              r_s0 <= in_data;
            end else begin
              r_s1 <= in_data;
            end
            r_nslot <= r_nslot + 2'd1;
            r_cnt   <= r_cnt + CW'(1);
            if (w_frame_end) begin
              r_fend <= 1'b1;
            end
          end
        end
        ST_ADD: begin
          r_acc   <= w_c;
          r_nslot <= 2'd0;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_acc  <= SM_ZERO;
            r_cnt  <= '0;
            r_fend <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output
  // ---------------------------------------------------------------------------
  always_comb begin
    w_out = (r_acc == SM_NEG_ZERO) ? SM_ZERO : r_acc;
`ifdef SIGMA_RELU_EN
    if (r_acc[31]) begin
      w_out = SM_ZERO;
    end
`else
`endif
  end

  assign out_valid   = (r_state == ST_DONE);
  assign out_data    = out_valid ? w_out : SM_ZERO;
  assign busy        = (r_state != ST_GATHER) || (r_cnt != '0);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sigma_accum_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sigma_accum_ctrl
// Scoreboard bench: every frame-ending term pushes the expected frame sum
// (plain integer arithmetic over the frame's terms) and the expected
// out_valid cycle; a negedge monitor pops and compares on each output.
// -----------------------------------------------------------------------------
module tb_sigma_accum_ctrl;

  localparam int N = 4;
  localparam logic [31:0] PI     = 32'h0006487e;
  localparam logic [31:0] NEG_PI = 32'h8006487e;
  localparam logic [31:0] NEG_E  = 32'h80056FC2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  logic   rand_ready = 1'b0;
  longint frame_sum  = 0;
  int     frame_cnt  = 0;

  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] prev_data  = 32'h0;

  sigma_accum_ctrl #(.N_TERMS(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / cycle counter
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Check helper and reference model
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint sm_to_int(input logic [31:0] d);
    longint m;
    m = longint'(d[30:0]);
    return d[31] ? -m : m;
  endfunction

  function automatic logic [31:0] model_out(input longint v);
    logic [31:0] r;
    if (v < 0) r = {1'b1, 31'(-v)};
    else       r = {1'b0, 31'(v)};
`ifdef SIGMA_RELU_EN
    if (v < 0) r = 32'h0;
`endif
    return r;
  endfunction

  function automatic void model_accept(input logic [31:0] d, input logic l, input int c);
    frame_sum += sm_to_int(d);
    frame_cnt++;
    if (l || frame_cnt == N) begin
      exp_q.push_back(model_out(frame_sum));
      lat_q.push_back(c + 2);
      frame_sum = 0;
      frame_cnt = 0;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (called at posedge + #1)
  // ---------------------------------------------------------------------------
  task automatic send_term(input logic [31:0] d, input logic l, output int acc_cyc);
    int waits;
    waits    = 0;
    acc_cyc  = -1;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && waits < 60) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1 after %0d cycles", waits);
    end else begin
      acc_cyc = cyc;
      model_accept(d, l, cyc);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: pending got %0d expected 0", exp_q.size());
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (out_valid) begin
        check("in_ready_in_done", {31'b0, in_ready}, 32'h0);
        check("busy_in_done", {31'b0, busy}, 32'h1);
        if (!prev_valid) begin
          if (lat_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
          end else begin
            check("out_valid_cycle", cyc, lat_q.pop_front());
          end
        end else if (!prev_ready) begin
          check("out_hold_stable", out_data, prev_data);
        end
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got %h expected none", out_data);
          end else begin
            check("out_data", out_data, exp_q.pop_front());
          end
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int a0, a1, a2;
    int len, gap;
    logic [31:0] d;
    logic [31:0] e5;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", {31'b0, in_ready}, 32'h1);
    check("reset_out_valid", {31'b0, out_valid}, 32'h0);
    check("reset_out_data", out_data, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    @(posedge clk);
    #1;

    // Three pi terms back to back: accepts at 0,1,3, out_valid at 5.
    send_term(PI, 1'b0, a0);
    send_term(PI, 1'b0, a1);
    send_term(PI, 1'b1, a2);
    check("second_accept_cycle", a1 - a0, 32'd1);
    check("third_accept_cycle", a2 - a0, 32'd3);
    wait_drain();

    // pi - e
    send_term(PI, 1'b0, a0);
    send_term(NEG_E, 1'b1, a1);
    wait_drain();

    // Four pi terms, implicit frame end at N
    for (int i = 0; i < 4; i++) send_term(PI, 1'b0, a0);
    wait_drain();

    // pi + (-pi) -> +0
    send_term(PI, 1'b0, a0);
    send_term(NEG_PI, 1'b1, a1);
    wait_drain();

    // Single negative term, output held for 3 cycles
`ifdef SIGMA_RELU_EN
    e5 = 32'h0;
`else
    e5 = NEG_PI;
`endif
    out_ready = 1'b0;
    send_term(NEG_PI, 1'b1, a0);
    a1 = 0;
    while (!out_valid && a1 < 10) begin
      @(negedge clk);
      a1++;
    end
    for (int i = 0; i < 3; i++) begin
      check("hold_out_valid", {31'b0, out_valid}, 32'h1);
      check("hold_out_data", out_data, e5);
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain();

    // Reset mid-frame discards partial terms
    send_term(PI, 1'b0, a0);
    @(negedge clk);
    check("busy_mid_frame", {31'b0, busy}, 32'h1);
    @(posedge clk);
    #1;
    send_term(PI, 1'b0, a1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    frame_sum = 0;
    frame_cnt = 0;
    @(negedge clk);
    check("rst_mid_in_ready", {31'b0, in_ready}, 32'h1);
    check("rst_mid_busy", {31'b0, busy}, 32'h0);
    check("rst_mid_out_valid", {31'b0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    send_term(PI, 1'b1, a0);
    wait_drain();

    // Randomized frames with random gaps and consumer back-pressure
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        d = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 1 << 20))};
        send_term(d, (i == len - 1), a0);
        if ($urandom_range(0, 3) == 0) begin
          in_data = $urandom;
          in_last = 1'($urandom_range(0, 1));
          gap = $urandom_range(1, 3);
          repeat (gap) @(posedge clk);
          #1 in_last = 1'b0;
        end
      end
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain();
    check("latency_queue_empty", lat_q.size(), 32'd0);
    @(negedge clk);
    check("final_busy", {31'b0, busy}, 32'h0);
    check("final_in_ready", {31'b0, in_ready}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
